ime_axil_host: RTL
==================

Name: ime_axil_host

Overview:
AXI-Lite initiator that drives the IME control plane, the CSR slave inside the IME top level. It accepts single register read or write commands from a local sequencer or test controller, performs exactly one AXI-Lite transaction per command, and returns the data and response. It also provides sticky timeout detection and an error counter so control-plane hangs and faults are observable.

Parameters:
ADDR_W, 16, AXI-Lite address width (matches IME CSR space)
DATA_W, 32, AXI-Lite data width
TIMEOUT_CYC, 256, busy cycles after which timeout_flag sets (must be >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  register byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  AXI response code
rsp_write  out  1  echo of cmd_write
m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read data channel
timeout_flag  out  1  sticky: a transaction exceeded TIMEOUT_CYC
clr_timeout  in  1  clears timeout_flag
err_count  out  8  saturating count of SLVERR/DECERR responses

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, all valid and ready outputs 0, rsp_rdata/rsp_resp/rsp_write=0, timeout_flag=0, err_count=0, busy counter=0.
- Reset mid-transaction aborts immediately: all valids drop in the next cycle. The system resets the slave together with this block.
- Exactly one outstanding transaction. cmd_ready = (state==IDLE).
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: on cmd_valid, register addr, wdata, wstrb and the write bit. Go to WR_REQ or RD_REQ. awvalid, wvalid or arvalid rise in the cycle after acceptance (registered).
- WR_REQ:
  - awvalid and wvalid are tracked independently; each drops the cycle after its own handshake.
  - Same-cycle handshakes on both channels are legal.
  - Go to WR_RESP once both handshakes have completed. bready=0 in WR_REQ.
- WR_RESP: bready=1. On bvalid, capture bresp and go to RSP (rsp_valid rises the next cycle).
- RD_REQ: arvalid=1 until arready, then RD_DATA. rready=0 in RD_REQ.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RSP.
- RSP: rsp_valid=1 with rsp_* stable until rsp_ready, then IDLE. A new command is not accepted in the rsp_ready cycle.
- Minimum latency with all readies high: accept at cycle 0, request at cycle 1, response captured at cycle 2, rsp_valid at cycle 3.
- Address and data outputs stay constant while their valid is high. The AXI rule that a valid never drops before its handshake is held even on timeout: no abort.
- Busy counter:
  - Increments every cycle outside IDLE and RSP, and clears on entering IDLE.
  - Saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC, timeout_flag=1. The flag holds until clr_timeout or rst.
  - If set and clear happen in the same cycle, set wins.
- err_count increments on capture of resp[1]==1 and saturates at 255. It is cleared only by rst.

Decomposition:
- Shared package ime_pkg:
  - axi_resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - the state enum
  - CSR address localparams used by sequencers (MODE, FRAME_LEN, EPSILON_Q, BIST_CMD, STATUS)
- No sub-module. The FSM, channel trackers and counters live in a single module.

Test Plan:
- Write 0x0010 data 0x000000AB, wstrb 0xF, all readies high -> awvalid and wvalid at cycle 1, bready at cycle 2, rsp_valid at cycle 3 with rsp_resp=0 and rsp_rdata=0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid low from cycle 2, awvalid held through cycle 4, bready not high before both handshakes, single rsp.
- Read 0x0004, slave returns 0xDEADBEEF with rresp=0 after a 2-cycle arready delay -> rsp_rdata=0xDEADBEEF, rsp_write=0, exactly one arvalid handshake.
- 257 writes answered with bresp=2 -> err_count=255 (saturated). Each rsp_resp=2.
- TIMEOUT_CYC=16, bvalid withheld for 20 cycles -> timeout_flag=1 starting 16 busy cycles after issue, bready still high, transaction completes when bvalid arrives. Flag stays set until clr_timeout pulses.
- rst pulsed while in RD_REQ with arvalid high -> arvalid=0 next cycle, cmd_ready=1, timeout_flag=0, err_count=0. rsp_ready held low after a response -> cmd_ready stays 0.

Source files
------------

// File: rtl/ime_pkg.sv
// Shared types and CSR map for the IME control plane.
// The AXI-Lite host and the sequencers that drive it both import this package.
package ime_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi_resp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } host_state_e;

   localparam logic [15:0] CSR_MODE      = 16'h0000;
   localparam logic [15:0] CSR_FRAME_LEN = 16'h0004;
   localparam logic [15:0] CSR_EPSILON_Q = 16'h0008;
   localparam logic [15:0] CSR_BIST_CMD  = 16'h000C;
   localparam logic [15:0] CSR_STATUS    = 16'h0010;

endpackage

// File: rtl/ime_axil_host.sv
// Single-outstanding AXI-Lite initiator for the IME CSR slave, with a sticky
// busy-timeout flag and a saturating count of error responses.
module ime_axil_host
   import ime_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_write,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   output logic                timeout_flag,
   input  logic                clr_timeout,
   output logic [7:0]          err_count
);

   localparam int STRB_W = DATA_W / 8;
   localparam int BUSY_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(TIMEOUT_CYC);

   host_state_e         state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                write_q, write_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                arvalid_q, arvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;
   logic [BUSY_W-1:0]   busy_q, busy_d;
   logic                timeout_q, timeout_d;
   logic [7:0]          err_q, err_d;
   logic                capture;
   logic                busy_state;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      write_d   = write_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               write_d = cmd_write;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // Address and data channels retire independently, in either order or together.
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               capture = 1'b1;
               rdata_d = '0;
               resp_d  = m_axi_bresp;
               state_d = RSP;
            end
         end
         RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axi_rvalid) begin
               capture = 1'b1;
               rdata_d = m_axi_rdata;
               resp_d  = m_axi_rresp;
               state_d = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Busy time is only counted while waiting on the slave; RSP waits on our own consumer.
   always_comb begin
      busy_state = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_DATA);
      busy_d     = busy_q;
      if (state_d == IDLE) begin
         busy_d = '0;
      end else if (busy_state && (busy_q != BUSY_MAX)) begin
         busy_d = busy_q + 1'b1;
      end
      timeout_d = timeout_q && !clr_timeout;
      if ((busy_d == BUSY_MAX) && (busy_q != BUSY_MAX)) timeout_d = 1'b1;
      err_d = err_q;
      if (capture && resp_d[1] && (err_q != 8'hFF)) err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         write_q   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
         busy_q    <= '0;
         timeout_q <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         write_q   <= write_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign rsp_valid     = (state_q == RSP);
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign rsp_write     = write_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == WR_RESP);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == RD_DATA);
   assign timeout_flag  = timeout_q;
   assign err_count     = err_q;

endmodule
